// File: rtl/timer_dev_pkg.sv
// -----------------------------------------------------------------------------
// timer_dev_pkg
// Shared definitions for the memory-mapped timer:
//   - register byte offsets within the block and the matching word selects
//   - CTRL field bit positions
//   - MODE codes
//   - FSM state encoding
// -----------------------------------------------------------------------------
package timer_dev_pkg;

    // Register byte offsets relative to BASE_ADDR.
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_PRESET = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;

    // Word selects (addr[3:2]) that correspond to the offsets above.
    localparam logic [1:0] SEL_CTRL   = OFF_CTRL[3:2];
    localparam logic [1:0] SEL_PRESET = OFF_PRESET[3:2];
    localparam logic [1:0] SEL_COUNT  = OFF_COUNT[3:2];

    // CTRL layout: bit0 EN, bits2:1 MODE, bit3 IM; upper bits read as zero.
    localparam int CTRL_W        = 4;
    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_PERIODIC = 2'd1,
        MODE_RSVD2    = 2'd2,
        MODE_RSVD3    = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_dev.sv
// -----------------------------------------------------------------------------
// timer_dev
// Memory-mapped down-counting timer that sits behind the CPU bus bridge next to
// the data memory. Three word registers live at BASE_ADDR:
//   +0 CTRL   (EN, MODE, IM)   read/write
//   +4 PRESET                  read/write
//   +8 COUNT                   read-only
// When enabled the timer loads PRESET, counts down to zero, then raises an
// interrupt flag. One-shot modes clear EN and latch the flag until software
// writes CTRL or PRESET; periodic mode reloads and pulses the flag for a
// single cycle per period.
//
// Build option:
//   TIMER_PERIODIC_EN  defined   -> MODE 1 is periodic
//                      undefined -> MODE 1 behaves as one-shot (bits still
//                                   read back as written)
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   asynchronous active-high reset
//   addr   in  32   bridge byte address
//   WE     in   1   bridge write strobe
//   WD     in  32   bridge write data
//   RD     out 32   read data (combinational, zero when not selected)
//   IRQ    out  1   interrupt request = IM & flag
// -----------------------------------------------------------------------------
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h00007F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        WE,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        IRQ
);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [CTRL_W-1:0] ctrl_reg;
    logic [31:0]       preset_reg;
    logic [31:0]       count_reg;
    logic [31:0]       count_next;
    logic              irq_flag_reg;
    state_t            state_reg;
    state_t            state_next;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       block_sel;
    logic [1:0] reg_sel;
    logic       wr_ctrl;
    logic       wr_preset;

    // Range compare rather than a mask so the block occupies exactly three
    // words; addr[1:0] is don't-care inside the range.
    assign block_sel = (addr >= BASE_ADDR) && (addr <= (BASE_ADDR + 32'hB));
    assign reg_sel   = addr[3:2];
    assign wr_ctrl   = WE && block_sel && (reg_sel == SEL_CTRL);
    assign wr_preset = WE && block_sel && (reg_sel == SEL_PRESET);

    // ------------------------------------------------------------------
    // CTRL fields
    // ------------------------------------------------------------------
    logic en;
    logic im;
    logic periodic;

    assign en = ctrl_reg[CTRL_EN_BIT];
    assign im = ctrl_reg[CTRL_IM_BIT];

`ifdef TIMER_PERIODIC_EN
    assign periodic = (ctrl_reg[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_PERIODIC);
`else
    // Without the periodic option every MODE code runs one-shot.
    assign periodic = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM next-state and datapath control
    // ------------------------------------------------------------------
    logic irq_set;
    logic irq_clr_period;
    logic en_clr;

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        irq_set        = 1'b0;
        irq_clr_period = 1'b0;
        en_clr         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (en) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_next = preset_reg;
                state_next = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (count_reg != 32'd0) begin
                    // Decrement only from non-zero so COUNT never wraps.
                    count_next = count_reg - 32'd1;
                end else begin
                    state_next = ST_INT;
                    irq_set    = 1'b1;
                end
            end
            ST_INT: begin
                if (periodic) begin
                    // Dropping the flag on reload gives one high cycle per period.
                    state_next     = ST_LOAD;
                    irq_clr_period = 1'b1;
                end else begin
                    en_clr     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            count_reg    <= 32'd0;
            ctrl_reg     <= '0;
            preset_reg   <= 32'd0;
            irq_flag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;

            // A software CTRL write on the same edge as the one-shot EN
            // clear takes precedence: software intent wins.
            if (wr_ctrl) begin
                ctrl_reg <= WD[CTRL_W-1:0];
            end else if (en_clr) begin
                ctrl_reg[CTRL_EN_BIT] <= 1'b0;
            end

            // PRESET only feeds COUNT in LOAD, so a write mid-count is
            // picked up on the next reload.
            if (wr_preset) begin
                preset_reg <= WD;
            end

            // Writing CTRL or PRESET acknowledges a latched interrupt.
            if (irq_set) begin
                irq_flag_reg <= 1'b1;
            end else if (irq_clr_period || wr_ctrl || wr_preset) begin
                irq_flag_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt output
    // ------------------------------------------------------------------
    logic [31:0] rd_data;

    always_comb begin
        rd_data = 32'd0;
        if (block_sel) begin
            case (reg_sel)
                SEL_CTRL:   rd_data = {{(32-CTRL_W){1'b0}}, ctrl_reg};
                SEL_PRESET: rd_data = preset_reg;
                SEL_COUNT:  rd_data = count_reg;
                default:    rd_data = 32'd0;
            endcase
        end
    end

    assign RD  = rd_data;
    assign IRQ = im & irq_flag_reg;

endmodule

// File: tb/tb_timer_dev.sv
// -----------------------------------------------------------------------------
// tb_timer_dev
// Directed self-checking bench for timer_dev. Each task drives one scenario
// and compares bus reads / IRQ against hand-computed values. Periodic-mode
// expectations follow the TIMER_PERIODIC_EN build option.
// -----------------------------------------------------------------------------
module tb_timer_dev;

    localparam logic [31:0] BASE     = 32'h00007F00;
    localparam logic [31:0] A_CTRL   = BASE + 32'h0;
    localparam logic [31:0] A_PRESET = BASE + 32'h4;
    localparam logic [31:0] A_COUNT  = BASE + 32'h8;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    int          total;
    int          bad;
    logic [31:0] rdata;

    timer_dev #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .WE    (WE),
        .WD    (WD),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, ending 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus write; consumes exactly one rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] data);
        addr = a;
        WD   = data;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE   = 1'b0;
        addr = 32'h0;
        $display("write addr=%h data=%h", a, data);
    endtask

    // Combinational read; consumes 1 ns, no clock edge.
    task automatic bus_read(input logic [31:0] a, output logic [31:0] data);
        addr = a;
        #1;
        data = RD;
        addr = 32'h0;
        $display("read  addr=%h data=%h", a, data);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        tick(2);
        bus_read(A_CTRL, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=%h", rdata, 32'h0); end
        bus_read(A_PRESET, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_preset got=%h exp=%h", rdata, 32'h0); end
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_count got=%h exp=%h", rdata, 32'h0); end
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
        reset = 1'b0;
        tick(1);
    endtask

    // PRESET=3, CTRL=EN|IM, mode 0.
    task automatic test_oneshot();
        bus_write(A_PRESET, 32'd3);
        bus_write(A_CTRL, 32'h9);
        tick(1);                               // LOAD
        for (int k = 3; k >= 0; k--) begin
            tick(1);
            bus_read(A_COUNT, rdata);
            total++; if (rdata !== 32'(k)) begin bad++; $display("FAIL oneshot_count got=%0d exp=%0d", rdata, k); end
            total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL oneshot_irq_early got=%b exp=0", IRQ); end
        end
        tick(1);                               // INT
        total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL oneshot_irq_rise got=%b exp=1", IRQ); end
        tick(1);                               // back to IDLE, EN cleared
        bus_read(A_CTRL, rdata);
        total++; if (rdata !== 32'h8) begin bad++; $display("FAIL oneshot_ctrl_after got=%h exp=%h", rdata, 32'h8); end
        tick(3);
        total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL oneshot_irq_held got=%b exp=1", IRQ); end
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL oneshot_count_held got=%h exp=%h", rdata, 32'h0); end
    endtask

    // Same run with IM=0; IRQ never rises, and a later IM-only write clears the flag.
    task automatic test_masked();
        bus_write(A_CTRL, 32'h0);
        bus_write(A_CTRL, 32'h1);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL masked_irq cyc=%0d got=%b exp=0", k, IRQ); end
        end
        bus_read(A_CTRL, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL masked_ctrl_after got=%h exp=%h", rdata, 32'h0); end
        bus_write(A_CTRL, 32'h8);
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL masked_irq_after_im got=%b exp=0", IRQ); end
        tick(2);
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL masked_irq_later got=%b exp=0", IRQ); end
    endtask

    // PRESET=0: LOAD -> CNT -> INT with no decrement.
    task automatic test_preset_zero();
        bus_write(A_PRESET, 32'd0);
        bus_write(A_CTRL, 32'h9);
        tick(2);                               // now in CNT with COUNT=0
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL pz_irq_cnt got=%b exp=0", IRQ); end
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL pz_count got=%h exp=%h", rdata, 32'h0); end
        tick(1);
        total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL pz_irq_int got=%b exp=1", IRQ); end
        tick(1);
        bus_read(A_CTRL, rdata);
        total++; if (rdata !== 32'h8) begin bad++; $display("FAIL pz_ctrl got=%h exp=%h", rdata, 32'h8); end
        bus_write(A_CTRL, 32'h0);
    endtask

    // PRESET=2, MODE1: pulse every 5 cycles if periodic is built in, else latched.
    task automatic test_periodic();
        logic exp_irq;
        bus_write(A_PRESET, 32'd2);
        bus_write(A_CTRL, 32'hB);
        for (int k = 1; k <= 22; k++) begin
            tick(1);
`ifdef TIMER_PERIODIC_EN
            exp_irq = (k >= 5) && (((k - 5) % 5) == 0);
`else
            exp_irq = (k >= 5);
`endif
            total++; if (IRQ !== exp_irq) begin bad++; $display("FAIL periodic_irq cyc=%0d got=%b exp=%b", k, IRQ, exp_irq); end
        end
        bus_read(A_CTRL, rdata);
`ifdef TIMER_PERIODIC_EN
        total++; if (rdata !== 32'hB) begin bad++; $display("FAIL periodic_ctrl got=%h exp=%h", rdata, 32'hB); end
`else
        total++; if (rdata !== 32'hA) begin bad++; $display("FAIL periodic_ctrl got=%h exp=%h", rdata, 32'hA); end
`endif
        bus_write(A_CTRL, 32'h0);
        tick(3);
    endtask

    // Clear EN so COUNT freezes at 5; re-enable reloads PRESET.
    task automatic test_en_clear();
        bus_write(A_PRESET, 32'd10);
        bus_write(A_CTRL, 32'h9);
        tick(2);
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'd10) begin bad++; $display("FAIL enclr_load got=%0d exp=10", rdata); end
        tick(4);
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'd6) begin bad++; $display("FAIL enclr_pre got=%0d exp=6", rdata); end
        bus_write(A_CTRL, 32'h8);              // EN=0, IM kept
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'd5) begin bad++; $display("FAIL enclr_at5 got=%0d exp=5", rdata); end
        for (int k = 1; k <= 4; k++) begin
            tick(1);
            bus_read(A_COUNT, rdata);
            total++; if (rdata !== 32'd5) begin bad++; $display("FAIL enclr_hold cyc=%0d got=%0d exp=5", k, rdata); end
            total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL enclr_irq cyc=%0d got=%b exp=0", k, IRQ); end
        end
        bus_write(A_CTRL, 32'h9);
        tick(2);
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'd10) begin bad++; $display("FAIL enclr_reload got=%0d exp=10", rdata); end
        bus_write(A_CTRL, 32'h0);
        tick(2);
    endtask

    // PRESET write mid-count leaves COUNT alone until the next LOAD.
    task automatic test_preset_write();
        bus_write(A_PRESET, 32'd10);
        bus_write(A_CTRL, 32'h9);
        tick(4);
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'd8) begin bad++; $display("FAIL pw_pre got=%0d exp=8", rdata); end
        bus_write(A_PRESET, 32'd3);
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'd7) begin bad++; $display("FAIL pw_count got=%0d exp=7", rdata); end
        bus_read(A_PRESET, rdata);
        total++; if (rdata !== 32'd3) begin bad++; $display("FAIL pw_preset got=%0d exp=3", rdata); end
        tick(7);
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL pw_zero got=%0d exp=0", rdata); end
        tick(1);
        total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL pw_irq got=%b exp=1", IRQ); end
        tick(1);
        bus_read(A_CTRL, rdata);
        total++; if (rdata !== 32'h8) begin bad++; $display("FAIL pw_ctrl got=%h exp=%h", rdata, 32'h8); end
        bus_write(A_CTRL, 32'h9);
        tick(2);
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'd3) begin bad++; $display("FAIL pw_newload got=%0d exp=3", rdata); end
        bus_write(A_CTRL, 32'h0);
        tick(2);
    endtask

    // CTRL write on the INT-state edge beats the EN clear; MODE2 is one-shot.
    task automatic test_write_wins();
        bus_write(A_PRESET, 32'd1);
        bus_write(A_CTRL, 32'h9);
        tick(3);
        tick(1);                               // INT
        total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL ww_irq_int got=%b exp=1", IRQ); end
        bus_write(A_CTRL, 32'hD);              // same edge as EN clear
        bus_read(A_CTRL, rdata);
        total++; if (rdata !== 32'hD) begin bad++; $display("FAIL ww_ctrl got=%h exp=%h", rdata, 32'hD); end
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL ww_irq_clr got=%b exp=0", IRQ); end
        tick(3);                               // LOAD, CNT 1, CNT 0
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL ww_irq_cnt got=%b exp=0", IRQ); end
        tick(1);
        total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL ww_irq_m2 got=%b exp=1", IRQ); end
        tick(1);
        bus_read(A_CTRL, rdata);
        total++; if (rdata !== 32'hC) begin bad++; $display("FAIL ww_ctrl_m2 got=%h exp=%h", rdata, 32'hC); end
        total++; if (IRQ !== 1'b1) begin bad++; $display("FAIL ww_irq_held got=%b exp=1", IRQ); end
    endtask

    // Asynchronous reset with IRQ latched, then mid-count at COUNT=7.
    task automatic test_reset_mid();
        #2;
        reset = 1'b1;
        #1;
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", IRQ); end
        bus_read(A_CTRL, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%h exp=%h", rdata, 32'h0); end
        bus_read(A_PRESET, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_preset got=%h exp=%h", rdata, 32'h0); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_write(A_PRESET, 32'd10);
        bus_write(A_CTRL, 32'h9);
        tick(5);
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'd7) begin bad++; $display("FAIL rstm_pre got=%0d exp=7", rdata); end
        #2;
        reset = 1'b1;
        #1;
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rstm_count got=%h exp=%h", rdata, 32'h0); end
        bus_read(A_CTRL, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rstm_ctrl got=%h exp=%h", rdata, 32'h0); end
        bus_read(A_PRESET, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rstm_preset got=%h exp=%h", rdata, 32'h0); end
        total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL rstm_irq got=%b exp=0", IRQ); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick(1);
            total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL rstm_irq_after cyc=%0d got=%b exp=0", k, IRQ); end
        end
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rstm_count_after got=%h exp=%h", rdata, 32'h0); end
    endtask

    // Decode boundaries, read-only COUNT, unused word, out-of-range addresses.
    task automatic test_addr_decode();
        bus_write(BASE + 32'h7, 32'd5);
        bus_read(A_PRESET, rdata);
        total++; if (rdata !== 32'd5) begin bad++; $display("FAIL dec_preset_lsb got=%h exp=%h", rdata, 32'd5); end
        bus_write(A_COUNT, 32'hFFFF);
        tick(2);
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL dec_count_ro got=%h exp=%h", rdata, 32'h0); end
        bus_write(BASE + 32'hC, 32'h1234);
        bus_read(BASE + 32'hC, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL dec_word3 got=%h exp=%h", rdata, 32'h0); end
        bus_read(A_PRESET, rdata);
        total++; if (rdata !== 32'd5) begin bad++; $display("FAIL dec_preset_keep got=%h exp=%h", rdata, 32'd5); end
        bus_read(A_CTRL, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL dec_ctrl_keep got=%h exp=%h", rdata, 32'h0); end
        bus_write(32'h00003000, 32'h9);
        tick(3);
        bus_read(A_CTRL, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL dec_unsel_wr got=%h exp=%h", rdata, 32'h0); end
        bus_read(A_COUNT, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL dec_unsel_run got=%h exp=%h", rdata, 32'h0); end
        bus_write(A_CTRL, 32'h8);
        bus_read(32'h00003000, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL dec_rd_3000 got=%h exp=%h", rdata, 32'h0); end
        bus_read(BASE + 32'h3, rdata);
        total++; if (rdata !== 32'h8) begin bad++; $display("FAIL dec_rd_ctrl_lsb got=%h exp=%h", rdata, 32'h8); end
        bus_read(32'h00003004, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL dec_rd_3004 got=%h exp=%h", rdata, 32'h0); end
        tick(1);
        bus_read(BASE - 32'hC, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL dec_rd_below got=%h exp=%h", rdata, 32'h0); end
        bus_read(BASE + 32'h10, rdata);
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL dec_rd_above got=%h exp=%h", rdata, 32'h0); end
        bus_read(BASE + 32'h5, rdata);
        total++; if (rdata !== 32'd5) begin bad++; $display("FAIL dec_rd_preset_lsb got=%h exp=%h", rdata, 32'd5); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        WE    = 1'b0;
        addr  = 32'h0;
        WD    = 32'h0;

        test_reset();
        test_oneshot();
        test_masked();
        test_preset_zero();
        test_periodic();
        test_en_clear();
        test_preset_write();
        test_write_wins();
        test_reset_mid();
        test_addr_decode();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
